// File: rtl/pipe_delay_pkg.sv
// Shared helpers for the elastic delay pipeline: count-width sizing,
// payload bit reversal and valid-bit population count.
package pipe_delay_pkg;

    // Widest payload / deepest pipeline the helper functions handle.
    localparam int MAX_W = 256;

    // Width needed to hold a count in the range 0..depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Reverse the low w bits of x: result bit (w-1-i) takes x bit i.
    function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] x, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            r[w-1-i] = x[i];
        end
        return r;
    endfunction

    // Number of set bits in v.
    function automatic int popcount(input logic [MAX_W-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < MAX_W; i++) begin
            c = c + int'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_delay_elastic_stage.sv
// One pipeline slot: a valid flag and its payload register. The slot
// reports that it is handing its word on (adv) when it is full and the
// downstream side can take it this cycle.
module pipe_delay_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             advance,
    input  logic [WIDTH-1:0] din,
    output logic             v,
    output logic [WIDTH-1:0] d,
    output logic             adv
);

    logic             v_d;
    logic             v_q;
    logic [WIDTH-1:0] d_d;
    logic [WIDTH-1:0] d_q;

    // The word leaves this slot when the slot is full and downstream accepts.
    always_comb begin
        adv = v_q & advance;
    end

    // Next slot state: clear wins, then a reload, then an emptying hand-off.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (clear) begin
            v_d = 1'b0;
        end else if (load) begin
            v_d = 1'b1;
            d_d = din;
        end else if (adv) begin
            v_d = 1'b0;
        end else begin
            v_d = v_q;
        end
    end

    // Slot registers with synchronous reset to empty and zero payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v = v_q;
    assign d = d_q;

endmodule

// File: rtl/pipe_delay_elastic.sv
// Elastic N-stage delay pipeline with valid/ready handshake, bubble
// collapsing, flush, registered occupancy and optional payload reversal.
// The ready chain is purely combinational from out_ready to in_ready.
module pipe_delay_elastic
    import pipe_delay_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int REVERSE = 0,
    parameter int CNT_W   = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] occupancy
);

    logic [DEPTH-1:0] v_s;
    logic [DEPTH-1:0] adv_s;
    logic [DEPTH-1:0] ready_s;
    logic [DEPTH-1:0] load_s;
    logic [DEPTH-1:0] v_next_s;
    logic [WIDTH-1:0] d_s [DEPTH];
    logic [WIDTH-1:0] cap_data_s;
    logic             in_ready_s;
    logic [CNT_W-1:0] occ_d;
    logic [CNT_W-1:0] occ_q;

    // Payload as it is captured into stage 0, optionally bit-reversed.
    always_comb begin
        if (REVERSE != 0) begin
            cap_data_s = WIDTH'(bitrev(MAX_W'(in_data), WIDTH));
        end else begin
            cap_data_s = in_data;
        end
    end

    // Ready chain: slot k may hand on when slot k+1 is empty or handing on.
    always_comb begin
        ready_s            = '0;
        ready_s[DEPTH-1]   = out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            ready_s[k] = ~v_s[k+1] | ready_s[k+1];
        end
    end

    // Input acceptance: stage 0 free or emptying, and no flush this cycle.
    always_comb begin
        in_ready_s = ~flush & (~v_s[0] | adv_s[0]);
    end

    // Stage loads: stage 0 from the producer, later stages from their predecessor.
    always_comb begin
        load_s    = '0;
        load_s[0] = in_valid & in_ready_s;
        for (int k = 1; k < DEPTH; k++) begin
            load_s[k] = adv_s[k-1] & ~flush;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] din_s;

        if (k == 0) begin : g_first
            assign din_s = cap_data_s;
        end else begin : g_rest
            assign din_s = d_s[k-1];
        end

        pipe_delay_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .clear   (flush),
            .load    (load_s[k]),
            .advance (ready_s[k]),
            .din     (din_s),
            .v       (v_s[k]),
            .d       (d_s[k]),
            .adv     (adv_s[k])
        );
    end

    // Valid bits as they will be after this edge, used for the occupancy count.
    always_comb begin
        v_next_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            v_next_s[k] = ~flush & (load_s[k] | (v_s[k] & ~adv_s[k]));
        end
        occ_d = CNT_W'(popcount(MAX_W'(v_next_s)));
    end

    // Occupancy register, updated in step with the stage valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = v_s[DEPTH-1];
    assign out_data  = d_s[DEPTH-1];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_delay_elastic.sv
// Self-checking bench for pipe_delay_elastic. A queue of in-flight words,
// each tagged with its position in the pipe, predicts every output.
module tb_pipe_delay_elastic;

    localparam int D = 4;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] data;
        int           pos;
    } word_t;

    logic         clk       = 1'b0;
    logic         reset     = 1'b1;
    logic         flush     = 1'b0;
    logic         in_valid  = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [2:0]   occupancy;

    logic         flush2    = 1'b0;
    logic         out_ready2 = 1'b1;
    logic         in_valid2 = 1'b0;
    logic [4:0]   in_data2  = '0;
    logic         in_ready2;
    logic         out_valid2;
    logic [4:0]   out_data2;
    logic [2:0]   occupancy2;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    bit           chk_en   = 1'b0;
    word_t        mq[$];
    logic [W-1:0] sb[$];
    logic [W-1:0] out_log[$];
    int           out_cyc[$];
    int           n_deliv  = 0;
    bit           last_acc;
    bit           last_ov;
    bit           last_ov2;
    logic [4:0]   last_d2;

    always #5 clk = ~clk;

    pipe_delay_elastic #(.WIDTH(W), .DEPTH(D), .REVERSE(0)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .occupancy(occupancy)
    );

    pipe_delay_elastic #(.WIDTH(5), .DEPTH(D), .REVERSE(1)) dut_rev (
        .clk(clk), .reset(reset), .flush(flush2), .in_valid(in_valid2), .in_data(in_data2),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2),
        .out_ready(out_ready2), .occupancy(occupancy2)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs after the edge, check at the falling edge, advance the model.
    task automatic cycle(input bit rst, input bit fl, input bit iv, input logic [W-1:0] id,
                         input bit ordy, input bit iv2, input logic [4:0] id2);
        word_t nq[$];
        bit    exp_rdy;
        bit    exp_ov;
        int    lim;
        @(posedge clk);
        #1;
        reset = rst; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
        in_valid2 = iv2; in_data2 = id2;
        @(negedge clk);
        cyc++;
        exp_ov = (mq.size() > 0) && (mq[0].pos == D - 1);
        nq = mq;
        if (exp_ov && ordy) begin
            void'(nq.pop_front());
        end
        for (int j = 0; j < nq.size(); j++) begin
            if (j == 0) lim = D - 1;
            else        lim = nq[j-1].pos - 1;
            nq[j].pos = (nq[j].pos + 1 < lim) ? nq[j].pos + 1 : lim;
        end
        exp_rdy = !fl && (nq.size() == 0 || nq[nq.size()-1].pos != 0);
        if (chk_en) begin
            check("out_valid", 32'(out_valid), 32'(exp_ov));
            if (exp_ov) check("out_data", 32'(out_data), 32'(mq[0].data));
            check("in_ready", 32'(in_ready), 32'(exp_rdy));
            check("occupancy", 32'(occupancy), 32'(mq.size()));
            check("occ_vs_sb", 32'(occupancy), 32'(sb.size()));
        end
        last_acc = iv && (in_ready === 1'b1);
        last_ov  = (out_valid === 1'b1);
        last_ov2 = (out_valid2 === 1'b1);
        last_d2  = out_data2;
        if (last_ov && ordy) begin
            n_deliv++;
            out_log.push_back(out_data);
            out_cyc.push_back(cyc);
            if (sb.size() > 0) begin
                check("sb_order", 32'(out_data), 32'(sb.pop_front()));
            end else begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_extra: delivered 0x%0h with nothing outstanding (cycle %0d)", out_data, cyc);
            end
        end
        if (rst || fl) sb.delete();
        else if (last_acc) sb.push_back(id);
        mq = nq;
        if (rst || fl) mq.delete();
        else if (iv && exp_rdy) mq.push_back('{data: id, pos: 0});
        if (rst) chk_en = 1'b1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_acc;
        int first_ov;
        int rdy_low;
        int idx;
        int sent;
        bit v2_hist[8];
        logic [4:0] d2_hist[8];

        // Reset and post-reset state
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Unstalled stream 0x01..0x08
        out_log.delete(); out_cyc.delete();
        first_acc = -1; first_ov = -1; rdy_low = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b0, i < 8, 8'(i + 1), 1'b1, 1'b0, 5'd0);
            if (i < 8 && !last_acc) rdy_low++;
            if (last_acc && first_acc < 0) first_acc = cyc;
            if (last_ov && first_ov < 0) first_ov = cyc;
        end
        check("stream_latency", 32'(first_ov - first_acc), 32'd4);
        check("stream_ready_low", 32'(rdy_low), 32'd0);
        check("stream_count", 32'(out_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < out_log.size(); i++) begin
            check("stream_word", 32'(out_log[i]), 32'(i + 1));
        end

        // Backpressure fill then release
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
        out_log.delete(); out_cyc.delete();
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, idx < 6, 8'(32'hA0 + idx), 1'b0, 1'b0, 5'd0);
            if (last_acc) idx++;
        end
        check("bp_accepts", 32'(idx), 32'd4);
        check("bp_occupancy", 32'(occupancy), 32'd4);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, idx < 6, 8'(32'hA0 + idx), 1'b1, 1'b0, 5'd0);
            if (last_acc) idx++;
        end
        check("bp_out_count", 32'(out_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < out_log.size(); i++) begin
            check("bp_word", 32'(out_log[i]), 32'(32'hA0 + i));
        end
        for (int i = 0; i < 3 && i + 1 < out_cyc.size(); i++) begin
            check("bp_back_to_back", 32'(out_cyc[i+1] - out_cyc[i]), 32'd1);
        end

        // Random traffic, 1000 words
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
        n_deliv = 0; sent = 0;
        for (int c = 0; c < 20000 && sent < 1000; c++) begin
            cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 5'd0);
            if (last_acc) sent++;
        end
        for (int c = 0; c < 200 && mq.size() > 0; c++) begin
            cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0);
        end
        check("rand_sent", 32'(sent), 32'd1000);
        check("rand_delivered", 32'(n_deliv), 32'd1000);
        check("rand_outstanding", 32'(sb.size()), 32'd0);

        // Flush with three words in flight while the producer offers another
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 8'(32'h11 + i), 1'b0, 1'b0, 5'd0);
        end
        n_deliv = 0;
        cycle(1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 5'd0);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0);
        check("flush_occupancy", 32'(occupancy), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0);
        end
        check("flush_nothing_delivered", 32'(n_deliv), 32'd0);

        // Reversed payload on the WIDTH=5 instance
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 5'b10100);
        check("rev_in_ready", 32'(in_ready2), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 5'b10000);
        for (int j = 0; j < 6; j++) begin
            cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0);
            v2_hist[j] = last_ov2;
            d2_hist[j] = last_d2;
        end
        check("rev_early", 32'(v2_hist[1]), 32'd0);
        check("rev_valid0", 32'(v2_hist[2]), 32'd1);
        check("rev_data0", 32'(d2_hist[2]), 32'(5'b00101));
        check("rev_valid1", 32'(v2_hist[3]), 32'd1);
        check("rev_data1", 32'(d2_hist[3]), 32'(5'b00001));
        check("rev_drained", 32'(v2_hist[4]), 32'd0);

        // Reset mid-operation with three words in flight
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 8'(32'h5A + i), 1'b0, 1'b0, 5'd0);
        end
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
        check("mid_occupancy", 32'(occupancy), 32'd3);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        check("mid_rst_occupancy", 32'(occupancy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
